// File: rtl/link_master_fsm.sv
// rtl/link_master_fsm.sv - upstream sender for the 4-phase req/ack byte link
//
// Accepts bytes from a producer on a valid/ready port, buffers them in a
// DEPTH-entry FIFO and sends them one at a time to the link slave over a
// 4-phase req/ack handshake.
//
// Parameters:
//   DEPTH       FIFO entries (power of two, >= 2)
//   TIMEOUT     max cycles spent in REQ waiting for ack=1 (1..255)
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    producer has a byte
//   in_data     producer byte
//   in_ready    FIFO can accept a byte
//   ack         acknowledge from the link slave
//   req         request to the slave (registered)
//   data_out    byte under transfer (registered, stable while req=1)
//   busy        FIFO non-empty or FSM not idle
//   sent_count  bytes completed by a full handshake (wraps)
//   timeout_err sticky ack-timeout flag
module link_master_fsm #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       ack,
    output logic       req,
    output logic [7:0] data_out,
    output logic       busy,
    output logic [7:0] sent_count,
    output logic       timeout_err
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(DEPTH);
    localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_ACK_LOW
    } state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [7:0]    tmo_cnt;
    logic          xfer_good;
    logic          push;
    logic          pop;

    // in_ready looks only at the registered count, so a full FIFO refuses a
    // push even when a launch frees an entry on the same edge.
    assign in_ready = (count < DEPTH_C);
    assign push     = in_valid && in_ready;
    // The only consumer of the FIFO is the IDLE->REQ launch.
    assign pop      = (state == IDLE) && (count != '0);
    assign busy     = (state != IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req         <= 1'b0;
            data_out    <= 8'h00;
            sent_count  <= 8'h00;
            timeout_err <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            tmo_cnt     <= 8'h00;
            xfer_good   <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (count != '0) begin
                        data_out <= mem[rd_ptr];
                        req      <= 1'b1;
                        tmo_cnt  <= 8'h00;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (ack) begin
                        req       <= 1'b0;
                        xfer_good <= 1'b1;
                        state     <= WAIT_ACK_LOW;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Give up on this byte; it is dropped, not retried.
                        req         <= 1'b0;
                        timeout_err <= 1'b1;
                        xfer_good   <= 1'b0;
                        state       <= WAIT_ACK_LOW;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                WAIT_ACK_LOW: begin
                    // A late ack only stretches this state; req stays low.
                    if (!ack) begin
                        state <= IDLE;
                        if (xfer_good) begin
                            sent_count <= sent_count + 8'd1;
                        end
                    end
                end
                default: begin
                    req   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_link_master_fsm.sv
// tb/tb_link_master_fsm.sv - directed self-checking bench for link_master_fsm
module tb_link_master_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       ack;
    logic       req;
    logic [7:0] data_out;
    logic       busy;
    logic [7:0] sent_count;
    logic       timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    link_master_fsm #(.DEPTH(4), .TIMEOUT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .ack        (ack),
        .req        (req),
        .data_out   (data_out),
        .busy       (busy),
        .sent_count (sent_count),
        .timeout_err(timeout_err)
    );

    // Link slave model: samples req=1, latches data_out, holds ack high for
    // exactly 2 cycles, then waits for the next request.
    logic       slave_en;
    logic       s_ack;
    logic [1:0] s_cnt;
    logic [7:0] rx_buf [1024];
    int         rx_n = 0;
    assign ack = s_ack;

    always @(posedge clk) begin
        if (rst) begin
            s_ack <= 1'b0;
            s_cnt <= 2'd0;
        end else if (s_cnt != 2'd0) begin
            s_cnt <= s_cnt - 2'd1;
            if (s_cnt == 2'd1) s_ack <= 1'b0;
        end else if (slave_en && req) begin
            if (rx_n < 1024) rx_buf[rx_n] <= data_out;
            rx_n  <= rx_n + 1;
            s_ack <= 1'b1;
            s_cnt <= 2'd2;
        end
    end

    // Cycle counter and launch log (edge index at which req rose).
    int   cyc = 0;
    logic prev_req = 1'b0;
    int   launch_at [1024];
    int   launch_n = 0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        prev_req <= req;
    end

    always @(negedge clk) begin
        if (req && !prev_req) begin
            if (launch_n < 1024) launch_at[launch_n] <= cyc;
            launch_n <= launch_n + 1;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Push n bytes base, base+1, ... honoring in_ready; returns at the
    // negedge following the last push edge.
    task automatic push_stream(input int n, input logic [7:0] base);
        int   i     = 0;
        int   guard = 0;
        logic pushing;
        in_valid = 1'b1;
        in_data  = base;
        while (i < n && guard < 5000) begin
            pushing = in_ready;
            @(negedge clk);
            if (pushing) i++;
            in_data = base + 8'(i);
            guard++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (i != n) begin
            n_fail++;
            $display("FAIL push_stream: pushed %0d bytes, required %0d", i, n);
        end
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while (busy && k < bound) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (busy) begin
            n_fail++;
            $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, bound);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b, required 0", req); end
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h, required 00", data_out); end
        n_checks++; if (sent_count !== 8'h00) begin n_fail++; $display("FAIL reset_sent_count: got %0d, required 0", sent_count); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %0b, required 0", timeout_err); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b, required 1", in_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b, required 0", busy); end
    endtask

    task automatic test_single();
        int rx0;
        do_reset();
        rx0 = rx_n;
        push_stream(1, 8'hA5);
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL single_req_after_push: got %0b, required 0", req); end
        @(negedge clk);
        n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL single_req_launch: got %0b, required 1", req); end
        n_checks++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL single_data_out: got %h, required a5", data_out); end
        repeat (3) @(negedge clk);
        n_checks++; if (sent_count !== 8'd0) begin n_fail++; $display("FAIL single_count_early: got %0d, required 0", sent_count); end
        @(negedge clk);
        n_checks++; if (sent_count !== 8'd1) begin n_fail++; $display("FAIL single_sent_count: got %0d, required 1", sent_count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %0b, required 0", busy); end
        n_checks++; if (rx_n != rx0 + 1 || rx_buf[rx0] !== 8'hA5) begin n_fail++; $display("FAIL single_last_byte: got %h (n=%0d), required a5", rx_buf[rx0], rx_n - rx0); end
    endtask

    task automatic test_back_to_back();
        int rx0;
        int l0;
        do_reset();
        rx0 = rx_n;
        l0  = launch_n;
        push_stream(5, 8'h01);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready_full: got %0b, required 0", in_ready); end
        wait_idle(100);
        n_checks++; if (sent_count !== 8'd5) begin n_fail++; $display("FAIL b2b_sent_count: got %0d, required 5", sent_count); end
        n_checks++; if (rx_n - rx0 != 5) begin n_fail++; $display("FAIL b2b_rx_count: got %0d, required 5", rx_n - rx0); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rx_buf[rx0 + i] !== 8'(i + 1)) begin
                n_fail++;
                $display("FAIL b2b_order[%0d]: got %h, required %h", i, rx_buf[rx0 + i], 8'(i + 1));
            end
        end
        for (int i = 1; i < 5; i++) begin
            n_checks++;
            if (launch_at[l0 + i] - launch_at[l0 + i - 1] != 5) begin
                n_fail++;
                $display("FAIL b2b_launch_gap[%0d]: got %0d, required 5", i, launch_at[l0 + i] - launch_at[l0 + i - 1]);
            end
        end
    endtask

    task automatic test_timeout();
        int hi = 0;
        int rx0;
        do_reset();
        slave_en = 1'b0;
        push_stream(1, 8'h77);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req) hi++;
        end
        n_checks++; if (hi != 15) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d, required 15", hi); end
        n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_set: got %0b, required 1", timeout_err); end
        n_checks++; if (sent_count !== 8'd0) begin n_fail++; $display("FAIL timeout_sent_count: got %0d, required 0", sent_count); end
        slave_en = 1'b1;
        rx0 = rx_n;
        push_stream(1, 8'h42);
        wait_idle(50);
        n_checks++; if (rx_n != rx0 + 1 || rx_buf[rx0] !== 8'h42) begin n_fail++; $display("FAIL timeout_next_byte: got %h (n=%0d), required 42", rx_buf[rx0], rx_n - rx0); end
        n_checks++; if (sent_count !== 8'd1) begin n_fail++; $display("FAIL timeout_next_count: got %0d, required 1", sent_count); end
        n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_sticky: got %0b, required 1", timeout_err); end
    endtask

    task automatic test_wrap();
        int rx0;
        do_reset();
        push_stream(255, 8'h00);
        wait_idle(200);
        n_checks++; if (sent_count !== 8'd255) begin n_fail++; $display("FAIL wrap_preload: got %0d, required 255", sent_count); end
        rx0 = rx_n;
        push_stream(1, 8'h3C);
        wait_idle(50);
        n_checks++; if (sent_count !== 8'd0) begin n_fail++; $display("FAIL wrap_sent_count: got %0d, required 0", sent_count); end
        n_checks++; if (rx_buf[rx0] !== 8'h3C) begin n_fail++; $display("FAIL wrap_byte: got %h, required 3c", rx_buf[rx0]); end
    endtask

    task automatic test_reset_mid();
        int hi = 0;
        do_reset();
        slave_en = 1'b0;
        push_stream(4, 8'h10);
        n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL rmid_in_req: got %0b, required 1", req); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL rmid_req: got %0b, required 0", req); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %0b, required 0", busy); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %0b, required 1", in_ready); end
        n_checks++; if (sent_count !== 8'd0) begin n_fail++; $display("FAIL rmid_sent_count: got %0d, required 0", sent_count); end
        slave_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (req) hi++;
        end
        n_checks++; if (hi != 0) begin n_fail++; $display("FAIL rmid_no_req: got %0d req cycles, required 0", hi); end
    endtask

    task automatic test_same_edge();
        int rx0;
        do_reset();
        rx0 = rx_n;
        push_stream(3, 8'h21);
        repeat (3) @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL same_ready_before: got %0b, required 1", in_ready); end
        in_valid = 1'b1;
        in_data  = 8'h24;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (!(req && !prev_req)) begin n_fail++; $display("FAIL same_launch_edge: got req=%0b prev=%0b, required 1/0", req, prev_req); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL same_ready_after: got %0b, required 1", in_ready); end
        push_stream(1, 8'h25);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL same_count_three: got in_ready=%0b, required 1", in_ready); end
        wait_idle(100);
        n_checks++; if (sent_count !== 8'd5) begin n_fail++; $display("FAIL same_sent_count: got %0d, required 5", sent_count); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rx_buf[rx0 + i] !== 8'(8'h21 + i)) begin
                n_fail++;
                $display("FAIL same_order[%0d]: got %h, required %h", i, rx_buf[rx0 + i], 8'(8'h21 + i));
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        slave_en = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_wrap();
        test_reset_mid();
        test_same_edge();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
